// File: rtl/tx_word_feeder_pkg.sv
// Shared definitions for the word-to-byte transmit feeder.
//   state_e        : 2-bit FSM encoding (IDLE, STROBE, WAIT_ACK, WAIT_DONE)
//   BYTES_PER_WORD : bytes sent per 32-bit word
//   WORD_W         : width of a result word
package tx_word_feeder_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STROBE    = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/word_fifo.sv
// Synchronous FIFO holding result words ahead of the byte serialiser.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write data_i (ignored when full without a same-cycle pop,
//                and ignored while flush_i is high)
//   pop_i      : drop the head entry (ignored when empty)
//   flush_i    : synchronous clear of pointers and level
//   head_o     : current head entry (valid when !empty_o)
//   level_o    : number of entries held
//   empty_o    : level_o == 0
module word_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic [AW:0]      level_o,
  output logic             empty_o
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full, do_push, do_pop;

  assign full    = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push at full is safe when the head leaves in the same cycle: the slot
  // being overwritten is the one being read out on this edge.
  assign do_push = push_i && !flush_i && (!full || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // Pointers are exactly AW bits, so increments wrap modulo DEPTH.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; contents are meaningless once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/tx_word_feeder.sv
// Buffers 32-bit result words and feeds them LSB-first, one byte at a time,
// to a serial transmitter using a strobe / busy handshake.
//   clk, rst              : clock, asynchronous active-low reset
//   word_in, word_valid   : incoming word; transfer when word_valid && word_ready
//   word_ready            : FIFO has room
//   flush                 : discard queued words (a word already started finishes)
//   tx_data, tx_new_data  : byte and one-cycle send strobe, both straight from flops
//   tx_busy               : transmitter busy (registered on the transmitter side)
//   level                 : words held in the FIFO
//   idle                  : FIFO empty and FSM idle
module tx_word_feeder
  import tx_word_feeder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_W-1:0]      word_in,
  input  logic                   word_valid,
  output logic                   word_ready,
  input  logic                   flush,
  output logic [7:0]             tx_data,
  output logic                   tx_new_data,
  input  logic                   tx_busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   idle
);

  localparam int          LW      = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  state_e            state_q, state_d;
  logic [WORD_W-9:0] sreg_q, sreg_d;     // bytes still to send after tx_data
  idx_t              idx_q, idx_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_new_q, tx_new_d;

  logic              fifo_push, fifo_pop, fifo_empty;
  logic [WORD_W-1:0] fifo_head;

  assign word_ready = (level != DEPTH_L);
  assign fifo_push  = word_valid && word_ready;

  word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (fifo_push),
    .data_i  (word_in),
    .pop_i   (fifo_pop),
    .flush_i (flush),
    .head_o  (fifo_head),
    .level_o (level),
    .empty_o (fifo_empty)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (!fifo_empty && !tx_busy) state_d = ST_STROBE;
      ST_STROBE:    state_d = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (tx_busy) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!tx_busy) state_d = (idx_q == LAST_IDX) ? ST_IDLE : ST_STROBE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values. The strobe flop is set on every entry into
  // STROBE so it is high exactly for the STROBE cycle.
  always_comb begin
    sreg_d    = sreg_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;
    fifo_pop  = 1'b0;
    if (state_q == ST_IDLE && state_d == ST_STROBE) begin
      fifo_pop  = 1'b1;
      tx_data_d = fifo_head[7:0];
      sreg_d    = fifo_head[WORD_W-1:8];
      idx_d     = '0;
    end else if (state_q == ST_WAIT_DONE && state_d == ST_STROBE) begin
      tx_data_d = sreg_q[7:0];
      sreg_d    = sreg_q >> 8;
      idx_d     = idx_q + IDX_W'(1);
    end
    tx_new_d = (state_d == ST_STROBE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg_q    <= '0;
      idx_q     <= '0;
      tx_data_q <= 8'h00;
      tx_new_q  <= 1'b0;
    end else begin
      sreg_q    <= sreg_d;
      idx_q     <= idx_d;
      tx_data_q <= tx_data_d;
      tx_new_q  <= tx_new_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_new_data = tx_new_q;
  assign idle        = (level == '0) && (state_q == ST_IDLE);

endmodule

// File: tb/tb_tx_word_feeder.sv
module tb_tx_word_feeder;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   word_in = '0;
  logic          word_valid = 1'b0;
  logic          word_ready;
  logic          flush = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_new_data;
  logic          tx_busy;
  logic [LW-1:0] level;
  logic          idle;

  always #5 clk = ~clk;

  tx_word_feeder #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .flush       (flush),
    .tx_data     (tx_data),
    .tx_new_data (tx_new_data),
    .tx_busy     (tx_busy),
    .level       (level),
    .idle        (idle)
  );

  int         n_cmp = 0, n_fail = 0, n_strobe = 0;
  logic [7:0] sb[$];

  // Transmitter model: busy rises the cycle after a strobe, lasts busy_len
  // cycles (or a random 1..6); busy_force models a blocked transmitter.
  int busy_cnt = 0, busy_len = 20;
  bit busy_rand = 0, busy_force = 0;
  always @(posedge clk) begin
    if (tx_new_data) busy_cnt <= busy_rand ? int'($urandom_range(6, 1)) : busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = busy_force | (busy_cnt != 0);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rev(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Drive one word, wait for room, log its bytes in send order.
  task automatic push_word(input logic [31:0] w, input logic [31:0] ord);
    int n = 0;
    word_in = w; word_valid = 1'b1;
    while (!word_ready && n < 500) begin tick(); n++; end
    if (!word_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL push_timeout: word %h not accepted, word_ready stuck low", w);
      word_valid = 1'b0;
      return;
    end
    for (int k = 0; k < 4; k++) sb.push_back(ord[31-8*k -: 8]);
    tick();
    word_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int t = 0;
    while (!(idle && !tx_busy) && t < budget) begin tick(); t++; end
    if (!(idle && !tx_busy)) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: idle=%0b busy=%0b, expected idle within %0d cycles", name, idle, tx_busy, budget);
    end
  endtask

  // Scoreboard monitor: every strobe consumes one expected byte.
  initial begin
    logic [7:0] e;
    logic       prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && tx_new_data) begin
        n_strobe++;
        check("strobe_one_cycle", {31'h0, prev}, 32'h0);
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_strobe: got byte %h, expected no strobe", tx_data);
        end else begin
          e = sb.pop_front();
          check("tx_byte", {24'h0, tx_data}, {24'h0, e});
        end
      end
      prev = rst && tx_new_data;
    end
  end

  typedef struct {
    logic [31:0] word;
    logic [31:0] order;   // expected bytes in send order, first byte in [31:24]
    int          busy;
  } vec_t;

  vec_t vecs[5];
  int   base, seen, t;

  initial begin
    vecs[0] = '{32'h12345678, 32'h78563412, 1};
    vecs[1] = '{32'h00000000, 32'h00000000, 3};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2};
    vecs[3] = '{32'h80000001, 32'h01000080, 7};
    vecs[4] = '{32'h0F1E2D3C, 32'h3C2D1E0F, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_new_data", {31'h0, tx_new_data}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_idle", {31'h0, idle}, 32'h1);
    check("rst_word_ready", {31'h0, word_ready}, 32'h1);
    rst = 1'b1;

    // Single word right after reset release: strobe one cycle after the push.
    busy_len = 20;
    base = n_strobe;
    push_word(32'hA1B2C3D4, 32'hD4C3B2A1);
    tick();
    check("latency_strobe", {31'h0, tx_new_data}, 32'h1);
    check("latency_byte0", {24'h0, tx_data}, 32'hD4);
    wait_idle(400, "single");
    check("single_strobes", n_strobe - base, 4);
    check("single_idle", {31'h0, idle}, 32'h1);

    // Table of words with differing transmitter busy lengths
    for (int i = 0; i < 5; i++) begin
      busy_len = vecs[i].busy;
      base = n_strobe;
      push_word(vecs[i].word, vecs[i].order);
      wait_idle(400, "vec");
      check("vec_strobes", n_strobe - base, 4);
      check("vec_level", 32'(level), 32'h0);
    end

    // Fill to full with the transmitter blocked
    busy_force = 1;
    base = n_strobe;
    for (int i = 0; i < 8; i++) push_word(32'h10000000 + i, rev(32'h10000000 + i));
    check("full_word_ready", {31'h0, word_ready}, 32'h0);
    check("full_level", 32'(level), 32'd8);
    check("full_no_strobe", n_strobe - base, 0);
    check("full_idle", {31'h0, idle}, 32'h0);

    // Release with a 9th word waiting: refills straight back to full
    busy_len = 3;
    busy_force = 0;
    push_word(32'hCAFE0009, rev(32'hCAFE0009));
    check("refill_level", 32'(level), 32'd8);
    check("refill_word_ready", {31'h0, word_ready}, 32'h0);
    wait_idle(3000, "drain");
    check("drain_strobes", n_strobe - base, 36);
    check("drain_sb_empty", sb.size(), 0);

    // Pointer wrap: 20 words with random busy lengths
    busy_rand = 1;
    base = n_strobe;
    for (int i = 0; i < 20; i++) push_word(i, rev(i));
    wait_idle(3000, "stream");
    check("stream_strobes", n_strobe - base, 80);
    check("stream_sb_empty", sb.size(), 0);
    busy_rand = 0;

    // Flush during WAIT_DONE of byte 1 with 3 words queued
    busy_len = 4;
    busy_force = 1;
    for (int i = 0; i < 4; i++) push_word(32'hF0F1F2F3 + i, rev(32'hF0F1F2F3 + i));
    busy_force = 0;
    base = n_strobe;
    seen = 0; t = 0;
    while (seen < 2 && t < 200) begin
      tick(); t++;
      if (tx_new_data) seen++;
    end
    check("flush_reach_byte1", seen, 2);
    tick();                     // WAIT_ACK
    tick();                     // WAIT_DONE
    check("flush_pre_level", 32'(level), 32'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_level", 32'(level), 32'h0);
    while (sb.size() > 2) void'(sb.pop_back());
    wait_idle(500, "flush");
    check("flush_strobes", n_strobe - base, 4);
    check("flush_sb_empty", sb.size(), 0);

    // Asynchronous reset during WAIT_ACK
    busy_len = 5;
    push_word(32'h11223344, rev(32'h11223344));
    push_word(32'h55667788, rev(32'h55667788));
    tick();                     // STROBE -> WAIT_ACK
    rst = 1'b0;
    #1;
    check("arst_tx_new_data", {31'h0, tx_new_data}, 32'h0);
    check("arst_tx_data", {24'h0, tx_data}, 32'h0);
    check("arst_level", 32'(level), 32'h0);
    check("arst_idle", {31'h0, idle}, 32'h1);
    sb.delete();
    base = n_strobe;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (30) tick();
    check("arst_no_strobe", n_strobe - base, 0);
    check("arst_idle_after", {31'h0, idle}, 32'h1);

    // Recovery after reset
    busy_len = 2;
    push_word(32'hDEADBEEF, 32'hEFBEADDE);
    tick();
    check("recover_strobe", {31'h0, tx_new_data}, 32'h1);
    wait_idle(400, "recover");
    check("recover_strobes", n_strobe - base, 4);
    check("recover_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
